// File: rtl/skinny_lw_pkg.sv
// skinny_lw_pkg: shared FSM encoding, round-constant constants and LFSR step for the SKINNY control stage
package skinny_lw_pkg;

   localparam int RCW            = 6;
   localparam int SK64_192_ROUNDS = 40;
   localparam logic [RCW-1:0] RC_INIT = 6'h01;

   // One-hot so every control output is a single-bit decode of the state register
   localparam int IDX_IDLE = 0;
   localparam int IDX_LOAD = 1;
   localparam int IDX_RUN  = 2;
   localparam int IDX_DONE = 3;

   typedef enum logic [3:0] {
      S_IDLE = 4'b0001,
      S_LOAD = 4'b0010,
      S_RUN  = 4'b0100,
      S_DONE = 4'b1000
   } state_t;

   function automatic logic [RCW-1:0] rc_next(input logic [RCW-1:0] v);
      return {v[4:0], ~(v[5] ^ v[4])};
   endfunction

endpackage

// File: rtl/skinny_rc_lfsr.sv
// skinny_rc_lfsr: 6-bit SKINNY round-constant LFSR
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   load       : load RC_INIT (takes priority over step)
//   step       : advance one LFSR step
//   rc         : current round constant
module skinny_rc_lfsr
   import skinny_lw_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           step,
   output logic [RCW-1:0] rc
);

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)
         rc <= '0;
      else if (load)
         rc <= RC_INIT;
      else if (step)
         rc <= rc_next(rc);

endmodule

// File: rtl/skinny_ctrl_lw.sv
// skinny_ctrl_lw: glitch-safe control for the masked SKINNY datapath (mux selects, round constant, sequencing)
//   clk, rst_n : clock, async active-low reset
//   start      : single-cycle request, sampled only in IDLE
//   sel_state  : 0 = load plaintext shares, 1 = round-function output
//   sel_tk     : 1 only in the last S-box stage of each round (tweakey update)
//   rc         : round constant of the current round
//   round_cnt  : completed rounds
//   busy       : high in LOAD and RUN
//   done       : one-cycle completion pulse
// Every output is a register bit or a one-bit decode of the one-hot state.
module skinny_ctrl_lw
   import skinny_lw_pkg::*;
#(
   parameter int ROUNDS      = SK64_192_ROUNDS,
   parameter int SBOX_STAGES = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         sel_state,
   output logic                         sel_tk,
   output logic [RCW-1:0]               rc,
   output logic [$clog2(ROUNDS+1)-1:0]  round_cnt,
   output logic                         busy,
   output logic                         done
);

   localparam int SW = (SBOX_STAGES > 1) ? $clog2(SBOX_STAGES) : 1;
   localparam int RW = $clog2(ROUNDS + 1);

   state_t        st;
   logic [SW-1:0] stage_cnt;
   logic          stage_last;
   logic          round_last;

   assign stage_last = stage_cnt == SW'(SBOX_STAGES - 1);
   assign round_last = round_cnt == RW'(ROUNDS - 1);

   assign busy      = st[IDX_LOAD] | st[IDX_RUN];
   assign sel_state = st[IDX_RUN] | st[IDX_DONE];
   assign done      = st[IDX_DONE];

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st        <= S_IDLE;
         stage_cnt <= '0;
         round_cnt <= '0;
         sel_tk    <= 1'b0;
      end else begin
         unique case (st)
            S_IDLE:
               if (start) begin
                  st        <= S_LOAD;
                  stage_cnt <= '0;
                  round_cnt <= '0;
               end
            S_LOAD: begin
               st     <= S_RUN;
               sel_tk <= 1'(SBOX_STAGES == 1);
            end
            S_RUN:
               if (stage_last) begin
                  stage_cnt <= '0;
                  round_cnt <= round_cnt + RW'(1);
                  st        <= round_last ? S_DONE : S_RUN;
                  sel_tk    <= round_last ? 1'b0 : 1'(SBOX_STAGES == 1);
               end else begin
                  stage_cnt <= stage_cnt + SW'(1);
                  // sel_tk is registered, so it is set one edge ahead of the boundary stage
                  sel_tk    <= (stage_cnt + SW'(1)) == SW'(SBOX_STAGES - 1);
               end
            S_DONE:
               st <= S_IDLE;
            default:
               st <= S_IDLE;
         endcase
      end

   // In RUN, sel_tk marks the boundary stage; rc holds on the terminating boundary
   skinny_rc_lfsr u_rc (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (st[IDX_IDLE] & start),
      .step  (sel_tk & ~round_last),
      .rc    (rc)
   );

endmodule

// File: tb/tb_skinny_ctrl_lw.sv
// tb_skinny_ctrl_lw: self-checking bench for skinny_ctrl_lw (default and SBOX_STAGES=1/ROUNDS=3 instances)
module tb_skinny_ctrl_lw;

   localparam int RA = 40, SA = 4;
   localparam int RB = 3,  SB = 1;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic       sel_state_a, sel_tk_a, busy_a, done_a;
   logic [5:0] rc_a, round_a;
   logic       sel_state_b, sel_tk_b, busy_b, done_b;
   logic [5:0] rc_b;
   logic [1:0] round_b;

   always #5 clk = ~clk;

   skinny_ctrl_lw dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .sel_state(sel_state_a), .sel_tk(sel_tk_a), .rc(rc_a),
      .round_cnt(round_a), .busy(busy_a), .done(done_a)
   );

   skinny_ctrl_lw #(.ROUNDS(RB), .SBOX_STAGES(SB)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .sel_state(sel_state_b), .sel_tk(sel_tk_b), .rc(rc_b),
      .round_cnt(round_b), .busy(busy_b), .done(done_b)
   );

   // SKINNY round constants, rounds 1..40
   logic [5:0] rc_tbl [40] = '{
      6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
      6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
      6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
      6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
   };

   int pass_cnt = 0;
   int total    = 0;
   int cyc      = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Model: e = clock edges since the start-sampling edge (-1 when idle)
   int ea = -1, eb = -1;
   int hra = 0, hrca = 0, hrb = 0, hrcb = 0;

   function automatic int next_e(input int e, input logic s, input int r, input int st);
      if (e < 0) return s ? 0 : -1;
      return (e == r * st + 1) ? -1 : e + 1;
   endfunction

   // {sel_state, sel_tk, busy, done, round[5:0], rc[5:0]}
   function automatic logic [15:0] expv(input int e, input int r, input int s, input int hr, input int hrc);
      int p;
      if (e < 0) return {4'b0000, 6'(hr), 6'(hrc)};
      if (e == 0) return {4'b0010, 6'd0, 6'h01};
      if (e <= r * s) begin
         p = e - 1;
         return {1'b1, 1'((p % s) == s - 1), 1'b1, 1'b0, 6'(p / s), rc_tbl[p / s]};
      end
      return {4'b1001, 6'(r), rc_tbl[r - 1]};
   endfunction

   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ea <= -1; eb <= -1;
         hra <= 0; hrca <= 0; hrb <= 0; hrcb <= 0;
      end else begin
         ea <= next_e(ea, start_a, RA, SA);
         eb <= next_e(eb, start_b, RB, SB);
         if (ea == RA * SA + 1) begin hra <= RA; hrca <= int'(rc_tbl[RA - 1]); end
         if (eb == RB * SB + 1) begin hrb <= RB; hrcb <= int'(rc_tbl[RB - 1]); end
      end

   always @(negedge clk) begin
      logic [15:0] xa, xb;
      xa = expv(ea, RA, SA, hra, hrca);
      xb = expv(eb, RB, SB, hrb, hrcb);
      chk("a.sel_state", sel_state_a, xa[15]);
      chk("a.sel_tk",    sel_tk_a,    xa[14]);
      chk("a.busy",      busy_a,      xa[13]);
      chk("a.done",      done_a,      xa[12]);
      chk("a.round_cnt", round_a,     xa[11:6]);
      chk("a.rc",        rc_a,        xa[5:0]);
      chk("b.sel_state", sel_state_b, xb[15]);
      chk("b.sel_tk",    sel_tk_b,    xb[14]);
      chk("b.busy",      busy_b,      xb[13]);
      chk("b.done",      done_b,      xb[12]);
      chk("b.round_cnt", round_b,     xb[11:6]);
      chk("b.rc",        rc_b,        xb[5:0]);
   end

   int         done_edge, round_at_done, tk_cnt, done_cnt, busy_end;
   logic [5:0] rc_log [8];

   // Start a run on dut_a; hold keeps start high until done is seen
   task automatic run_a(input bit hold);
      int c0, e, prev_round;
      done_edge = -1; round_at_done = -1; tk_cnt = 0; done_cnt = 0; prev_round = 0;
      @(negedge clk);
      start_a = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 175; i++) begin
         @(negedge clk);
         e = cyc - (c0 + 1);
         if (!hold) start_a = 1'b0;
         if (e == 0) begin
            chk("load.sel_state", sel_state_a, 0);
            chk("load.busy", busy_a, 1);
            chk("load.rc", rc_a, 1);
         end
         if (e == 1) begin
            chk("run.sel_state", sel_state_a, 1);
            chk("run.busy", busy_a, 1);
         end
         if (int'(round_a) < prev_round) chk("round monotonic", round_a, prev_round);
         prev_round = round_a;
         if (sel_tk_a) begin
            if (tk_cnt < 8) rc_log[tk_cnt] = rc_a;
            tk_cnt++;
         end
         if (done_a) begin
            done_cnt++;
            done_edge = e;
            round_at_done = round_a;
            start_a = 1'b0;
         end
      end
      busy_end = busy_a;
   endtask

   initial begin
      int c0, e;
      logic [5:0] exp8 [8] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B};
      logic [5:0] expb [3] = '{6'h01, 6'h03, 6'h07};
      int tk_b, done_b_edge, run_b;

      repeat (2) @(negedge clk);
      chk("reset.sel_state", sel_state_a, 0);
      chk("reset.busy", busy_a, 0);
      chk("reset.rc", rc_a, 0);
      chk("reset.round_cnt", round_a, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Full default run
      run_a(1'b0);
      chk("full.sel_tk pulses", tk_cnt, 40);
      chk("full.done edge", done_edge, 161);
      chk("full.round at done", round_at_done, 40);
      chk("full.done pulses", done_cnt, 1);
      chk("full.busy after", busy_end, 0);
      for (int i = 0; i < 8; i++) chk($sformatf("full.rc round %0d", i + 1), rc_log[i], exp8[i]);

      // start held through LOAD/RUN/DONE
      run_a(1'b1);
      chk("hold.done pulses", done_cnt, 1);
      chk("hold.done edge", done_edge, 161);
      chk("hold.sel_tk pulses", tk_cnt, 40);
      chk("hold.busy after", busy_end, 0);

      // Asynchronous reset in round 17, stage 2
      @(negedge clk);
      start_a = 1'b1;
      c0 = cyc;
      @(negedge clk);
      start_a = 1'b0;
      e = cyc - (c0 + 1);
      for (int i = 0; i < 100 && e < 67; i++) begin
         @(negedge clk);
         e = cyc - (c0 + 1);
      end
      chk("midrun.reached", e, 67);
      chk("midrun.round before", round_a, 16);
      #2 rst_n = 1'b0;
      #1;
      chk("areset.sel_state", sel_state_a, 0);
      chk("areset.sel_tk", sel_tk_a, 0);
      chk("areset.busy", busy_a, 0);
      chk("areset.done", done_a, 0);
      chk("areset.rc", rc_a, 0);
      chk("areset.round_cnt", round_a, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_a(1'b0);
      chk("after reset.done edge", done_edge, 161);
      chk("after reset.round at done", round_at_done, 40);

      // Single-stage, three-round instance
      tk_b = 0; done_b_edge = -1; run_b = 0;
      @(negedge clk);
      start_b = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start_b = 1'b0;
         e = cyc - (c0 + 1);
         if (sel_tk_b) begin
            if (tk_b < 3) chk($sformatf("b.rc round %0d", tk_b + 1), rc_b, expb[tk_b]);
            if (tk_b == 0 || run_b == e - 1) run_b = e;
            tk_b++;
         end
         if (done_b) done_b_edge = e;
      end
      chk("b.sel_tk pulses", tk_b, 3);
      chk("b.sel_tk last consecutive edge", run_b, 3);
      chk("b.done edge", done_b_edge, 4);
      chk("b.rc held", rc_b, 6'h07);
      chk("b.round held", round_b, 3);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
